// File: rtl/bbox_steer_gen.sv
// bbox_steer_gen: turns a three-word bounding-box message (ID, top-left,
// bottom-right) into a registered steering command (direction, near flag,
// box centre x and box width) with a valid/ready handshake on each side.
// Optional feature macro BBOX_MIN_WIDTH_FILTER_EN: when defined, boxes
// narrower than MIN_WIDTH are reported as "no object".
module bbox_steer_gen #(
    parameter int IMAGE_W    = 640,
    parameter int DEADBAND   = 32,
    parameter int NEAR_WIDTH = 160,
    parameter int MIN_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] msg_data,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_dir,
    output logic        cmd_near,
    output logic [10:0] cmd_cx,
    output logic [10:0] cmd_width,
    output logic [7:0]  err_count
);

    localparam logic [31:0] MSG_ID    = 32'h0052_4242;
    localparam logic [11:0] LEFT_LIM  = 12'(IMAGE_W / 2 - DEADBAND);
    localparam logic [11:0] RIGHT_LIM = 12'(IMAGE_W / 2 + DEADBAND);
    localparam logic [11:0] NEAR_LIM  = 12'(NEAR_WIDTH);

    typedef enum logic [2:0] {IDLE, TL, BR, CALC, OUT} state_t;

    state_t      state, state_next;
    logic [10:0] x_min, x_max;
    logic        accept, is_id, err_inc;

    logic [11:0] sum;
    logic [10:0] cx_calc, width_calc;
    logic [1:0]  dir_calc;
    logic        near_calc, empty;

    // Word accepted this edge; msg_ready held low while in reset.
    always_comb begin
        msg_ready = reset_n && (state == IDLE || state == TL || state == BR);
        accept    = msg_valid && msg_ready;
        is_id     = (msg_data == MSG_ID);
        cmd_valid = (state == OUT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic and protocol-error detection.
    always_comb begin
        state_next = state;
        err_inc    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (is_id) state_next = TL;
                else       err_inc    = 1'b1;
            end
            TL: if (accept) begin
                if (is_id) err_inc = 1'b1;    // resync: stay in TL for a fresh message
                else       state_next = BR;
            end
            BR: if (accept) begin
                if (is_id) begin
                    err_inc    = 1'b1;
                    state_next = TL;
                end else begin
                    state_next = CALC;
                end
            end
            CALC: state_next = OUT;
            OUT:  if (cmd_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command arithmetic on the latched x coordinates (y is ignored).
    always_comb begin
        sum        = {1'b0, x_min} + {1'b0, x_max};
        cx_calc    = sum[11:1];
        width_calc = x_max - x_min + 11'd1;
`ifdef BBOX_MIN_WIDTH_FILTER_EN
        empty      = (x_max < x_min) || ({1'b0, width_calc} < 12'(MIN_WIDTH));
`else
        empty      = (x_max < x_min);
`endif
        if ({1'b0, cx_calc} < LEFT_LIM)       dir_calc = 2'b01;
        else if ({1'b0, cx_calc} > RIGHT_LIM) dir_calc = 2'b10;
        else                                  dir_calc = 2'b11;
        near_calc  = ({1'b0, width_calc} >= NEAR_LIM);
    end

`ifndef BBOX_MIN_WIDTH_FILTER_EN
    // MIN_WIDTH only matters when the filter is built in.
    logic unused_min_width;
    assign unused_min_width = (MIN_WIDTH > 0);
`endif

    // Coordinate latches, command registers and saturating error counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_min     <= '0;
            x_max     <= '0;
            cmd_dir   <= '0;
            cmd_near  <= 1'b0;
            cmd_cx    <= '0;
            cmd_width <= '0;
            err_count <= '0;
        end else begin
            if (state == TL && accept && !is_id) x_min <= msg_data[26:16];
            if (state == BR && accept && !is_id) x_max <= msg_data[26:16];
            if (err_inc && err_count != 8'hFF)   err_count <= err_count + 8'd1;
            if (state == CALC) begin
                if (empty) begin
                    cmd_dir   <= 2'b00;
                    cmd_near  <= 1'b0;
                    cmd_cx    <= '0;
                    cmd_width <= '0;
                end else begin
                    cmd_dir   <= dir_calc;
                    cmd_near  <= near_calc;
                    cmd_cx    <= cx_calc;
                    cmd_width <= width_calc;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_steer_gen.sv
// Directed, table-driven bench for bbox_steer_gen with hand-computed
// expectations (defaults: IMAGE_W 640, DEADBAND 32, NEAR_WIDTH 160, MIN_WIDTH 8).
module tb_bbox_steer_gen;

    localparam logic [31:0] ID = 32'h0052_4242;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_dir;
    logic        cmd_near;
    logic [10:0] cmd_cx;
    logic [10:0] cmd_width;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    bbox_steer_gen dut (
        .clk(clk), .reset_n(reset_n),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_near(cmd_near), .cmd_cx(cmd_cx),
        .cmd_width(cmd_width), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] xmin, xmax;
        logic [1:0]  dir;
        logic        near;
        logic [10:0] cx, width;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [10:0] x, input logic [10:0] y);
        return {5'b0, x, 5'b0, y};
    endfunction

    // Present one word and hold it until accepted; inputs change #1 after edges.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        msg_data  = w;
        msg_valid = 1'b1;
        while (!msg_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("msg_ready_timeout", 0, 1);
        @(posedge clk); #1;
        msg_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [10:0] xmin, input logic [10:0] xmax);
        send_word(ID);
        send_word(mk(xmin, 11'd50));
        send_word(mk(xmax, 11'd90));
    endtask

    // After the BR word: one CALC cycle with nothing valid, then OUT.
    task automatic expect_cmd(input string name, input vec_t v);
        check({name, "_calc_valid"}, cmd_valid, 0);
        check({name, "_calc_ready"}, msg_ready, 0);
        @(posedge clk); #1;
        check({name, "_valid"}, cmd_valid, 1);
        check({name, "_dir"},   cmd_dir, v.dir);
        check({name, "_near"},  cmd_near, v.near);
        check({name, "_cx"},    cmd_cx, v.cx);
        check({name, "_width"}, cmd_width, v.width);
    endtask

    task automatic handshake(input string name);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        check({name, "_hs_valid"}, cmd_valid, 0);
        check({name, "_hs_ready"}, msg_ready, 1);
    endtask

    vec_t vecs[13];

    initial begin
        vec_t v;
        logic [1:0]  hold_dir;
        logic [10:0] hold_cx, hold_w;
        logic        hold_near;
        int          seen;

        //           xmin  xmax  dir    near  cx    width
        vecs[0]  = '{100,  140,  2'b01, 1'b0, 120,  41};
        vecs[1]  = '{300,  340,  2'b11, 1'b0, 320,  41};
        vecs[2]  = '{480,  639,  2'b10, 1'b1, 559,  160};
        vecs[3]  = '{639,  0,    2'b00, 1'b0, 0,    0};
        vecs[4]  = '{100,  141,  2'b01, 1'b0, 120,  42};
        vecs[5]  = '{284,  292,  2'b11, 1'b0, 288,  9};
        vecs[6]  = '{283,  291,  2'b01, 1'b0, 287,  9};
        vecs[7]  = '{348,  356,  2'b11, 1'b0, 352,  9};
        vecs[8]  = '{349,  357,  2'b10, 1'b0, 353,  9};
        vecs[9]  = '{0,    158,  2'b01, 1'b0, 79,   159};
        vecs[10] = '{2039, 2047, 2'b10, 1'b0, 2043, 9};
        vecs[11] = '{200,  207,  2'b01, 1'b0, 203,  8};
`ifdef BBOX_MIN_WIDTH_FILTER_EN
        vecs[12] = '{200,  204,  2'b00, 1'b0, 0,    0};
`else
        vecs[12] = '{200,  204,  2'b01, 1'b0, 202,  5};
`endif

        reset_n   = 1'b0;
        msg_data  = '0;
        msg_valid = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_msg_ready", msg_ready, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_err",       err_count, 0);
        check("rst_cx",        cmd_cx, 0);
        check("rst_width",     cmd_width, 0);
        check("rst_dir",       cmd_dir, 0);
        check("rst_near",      cmd_near, 0);
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", msg_ready, 1);

        for (int i = 0; i < 13; i++) begin
            send_msg(vecs[i].xmin, vecs[i].xmax);
            expect_cmd($sformatf("vec%0d", i), vecs[i]);
            handshake($sformatf("vec%0d", i));
            check($sformatf("vec%0d_keep_cx", i), cmd_cx, vecs[i].cx);
        end
        check("no_err_after_table", err_count, 0);

        // Backpressure: command held stable for 10 cycles.
        v = '{100, 140, 2'b01, 1'b0, 120, 41};
        send_msg(480, 639);
        v = '{480, 639, 2'b10, 1'b1, 559, 160};
        expect_cmd("bp", v);
        hold_dir = cmd_dir; hold_near = cmd_near; hold_cx = cmd_cx; hold_w = cmd_width;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_valid", cmd_valid, 1);
            check("bp_ready", msg_ready, 0);
            check("bp_stable", {cmd_dir, cmd_near, cmd_cx, cmd_width},
                  {hold_dir, hold_near, hold_cx, hold_w});
        end
        handshake("bp");

        // Stray word in IDLE.
        send_word(32'hDEAD_BEEF);
        check("stray_err", err_count, 1);
        check("stray_nocmd", cmd_valid, 0);

        // Resync: ID, TL, ID, TL, BR -> one command from the second message.
        send_word(ID);
        send_word(mk(11'd10, 11'd0));
        send_word(ID);
        check("resync_err", err_count, 2);
        check("resync_nocmd", cmd_valid, 0);
        send_word(mk(11'd100, 11'd0));
        send_word(mk(11'd140, 11'd0));
        v = '{100, 140, 2'b01, 1'b0, 120, 41};
        expect_cmd("resync", v);
        handshake("resync");
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (cmd_valid) seen++;
        end
        check("resync_one_cmd", seen, 0);

        // Reset mid-message discards the partial message.
        send_word(ID);
        send_word(mk(11'd100, 11'd0));
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midmsg_rst_ready", msg_ready, 0);
        check("midmsg_rst_err", err_count, 0);
        reset_n = 1'b1;
        #1;
        check("midmsg_post_ready", msg_ready, 1);
        send_word(mk(11'd140, 11'd0));
        check("midmsg_br_is_err", err_count, 1);
        @(posedge clk); #1;
        check("midmsg_nocmd", cmd_valid, 0);

        // Reset mid-OUT drops the command and clears outputs.
        send_msg(300, 340);
        @(posedge clk); #1;
        check("midout_valid", cmd_valid, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midout_rst_valid", cmd_valid, 0);
        check("midout_rst_cx", cmd_cx, 0);
        check("midout_rst_dir", cmd_dir, 0);
        #1;
        check("midout_post_ready", msg_ready, 1);

        // Error counter saturation: 2 then 300 stray words.
        send_word(32'h1234_5678);
        send_word(32'h0000_0001);
        check("sat_pre", err_count, 2);
        msg_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            msg_data = 32'(k + 2);
            @(posedge clk); #1;
        end
        msg_valid = 1'b0;
        check("sat_255", err_count, 255);
        check("sat_nocmd", cmd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
